// File: rtl/msk_prng_pkg.sv
// Shared types and constants for the masked-gadget randomness feeder.
// Holds the FSM state enum, LFSR geometry, feedback taps and zero-seed value.
package msk_prng_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_e;

  localparam int LFSR_W  = 128;
  localparam int SEED_W  = 32;
  localparam int N_CHUNK = 4;

  // x^128 + x^29 + x^27 + x^2 + 1 as 0-based register bit indices
  localparam int TAP0 = 127;
  localparam int TAP1 = 28;
  localparam int TAP2 = 26;
  localparam int TAP3 = 1;

  // An all-zero LFSR would lock up, so it is replaced by this value
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = {{(LFSR_W-1){1'b0}}, 1'b1};

endpackage

// File: rtl/msk_lfsr128_step.sv
// Combinational STEPS-fold unrolled advance of the 128-bit Fibonacci LFSR.
// Ports: state_i current state, state_o state after STEPS shifts toward MSB.
module msk_lfsr128_step
  import msk_prng_pkg::*;
#(
  parameter int STEPS = 20
) (
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] s;
  logic              fb;

  always_comb begin
    s  = state_i;
    fb = 1'b0;
    for (int i = 0; i < STEPS; i++) begin
      fb = s[TAP0] ^ s[TAP1] ^ s[TAP2] ^ s[TAP3];
      s  = {s[LFSR_W-2:0], fb};
    end
    state_o = s;
  end

endmodule

// File: rtl/msk_rnd_feeder.sv
// Seeded LFSR randomness producer for masked gadgets (refresh + mult buses).
// Ports: clk/rst, seed_data/valid/ready handshake, rnd_en/valid/ref/mul.
module msk_rnd_feeder
  import msk_prng_pkg::*;
#(
  parameter int RND_REF_W  = 4,
  parameter int RND_MUL_W  = 16,
  parameter int WARMUP_CYC = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEED_W-1:0]    seed_data,
  input  logic                 seed_valid,
  output logic                 seed_ready,
  input  logic                 rnd_en,
  output logic                 rnd_valid,
  output logic [RND_REF_W-1:0] rnd_ref,
  output logic [RND_MUL_W-1:0] rnd_mul
);

  localparam int N   = RND_REF_W + RND_MUL_W;
  localparam int WCW = $clog2(WARMUP_CYC + 1);
  localparam logic [WCW-1:0] WLAST = WCW'(WARMUP_CYC - 1);
  localparam logic [1:0]     CLAST = 2'(N_CHUNK - 1);

  state_e            state_q, state_d;
  logic [1:0]        chunk_q, chunk_d;
  logic [WCW-1:0]    warm_q, warm_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [LFSR_W-1:0] lfsr_adv, lfsr_ld;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;
  logic              seed_hs;

  assign seed_hs = seed_valid & ready_q;

  msk_lfsr128_step #(
    .STEPS(N)
  ) u_step (
    .state_i(lfsr_q),
    .state_o(lfsr_adv)
  );

  // The chunk counter wraps to 0 after the 4th chunk, so a reseed
  // from RUN naturally lands in chunk 0.
  always_comb begin
    lfsr_ld = lfsr_q;
    lfsr_ld[{chunk_q, 5'd0} +: SEED_W] = seed_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (seed_hs && chunk_q == CLAST) state_d = WARMUP;
      WARMUP:  if (warm_q == WLAST) state_d = RUN;
      RUN:     if (seed_hs) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    ready_d = (state_d != WARMUP);
    valid_d = (state_d == RUN);
  end

  always_comb begin
    chunk_d = chunk_q;
    warm_d  = warm_q;
    lfsr_d  = lfsr_q;
    unique case (state_q)
      LOAD: begin
        if (seed_hs) begin
          chunk_d = chunk_q + 2'd1;
          warm_d  = '0;
          lfsr_d  = lfsr_ld;
          if (chunk_q == CLAST && lfsr_ld == '0)
            lfsr_d = ZERO_SEED_SUB;
        end
      end
      WARMUP: begin
        lfsr_d = lfsr_adv;
        warm_d = warm_q + 1'b1;
      end
      RUN: begin
        if (seed_hs) begin
          chunk_d = chunk_q + 2'd1;
          lfsr_d  = lfsr_ld;
        end else if (rnd_en && valid_q) begin
          lfsr_d = lfsr_adv;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chunk_q <= '0;
      warm_q  <= '0;
      lfsr_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      chunk_q <= chunk_d;
      warm_q  <= warm_d;
      lfsr_q  <= lfsr_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign seed_ready = ready_q;
  assign rnd_valid  = valid_q;
  assign rnd_ref = lfsr_q[RND_REF_W-1:0] & {RND_REF_W{valid_q}};
  assign rnd_mul = lfsr_q[N-1:RND_REF_W] & {RND_MUL_W{valid_q}};

endmodule

// File: doc/msk_rnd_feeder.md
# msk_rnd_feeder

Seeded pseudo-random source that supplies fresh randomness to masked gadgets: the refresh (`rnd_ref`) and multiplication (`rnd_mul`) buses of the HPC1 GF(16) multiplier and similar consumers. It is the producer end of the gadget randomness interface. A 128-bit LFSR is loaded through a 32-bit seed handshake, warmed up, and then advanced on consumer demand. Outputs are forced to zero whenever they are not valid, so stale or partially seeded state never reaches a gadget.

## Interface
Parameters:
- `RND_REF_W`, default 4: width of the refresh randomness bus (4·ref_n_rnd for the consumer's d).
- `RND_MUL_W`, default 16: width of the multiplication randomness bus (4·dom_rnd for the consumer's d).
- `WARMUP_CYC`, default 128: number of LFSR advances discarded after seeding. Must be ≥ 1.
- Constraint: `RND_REF_W + RND_MUL_W ≤ 64`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `seed_data`  in  32  seed chunk.
- `seed_valid`  in  1  chunk present.
- `seed_ready`  out  1  chunk can be accepted.
- `rnd_en`  in  1  consumer takes the current randomness this cycle.
- `rnd_valid`  out  1  `rnd_ref`/`rnd_mul` carry fresh randomness.
- `rnd_ref`  out  RND_REF_W  refresh randomness.
- `rnd_mul`  out  RND_MUL_W  multiplication randomness.

## Operation
- States: LOAD, WARMUP, RUN. Reset enters LOAD with chunk count 0, warmup count 0 and LFSR = 0.
- LOAD:
  - `seed_ready`=1.
  - Each handshake (`seed_valid & seed_ready`) writes `seed_data` into LFSR bits [32k+31:32k], where k is the chunk count, then k increments.
  - On the 4th chunk, go to WARMUP.
  - If the fully assembled 128-bit seed is all-zero, the LFSR is loaded with 128'h1 instead.
- WARMUP:
  - `seed_ready`=0.
  - The LFSR advances N = RND_REF_W+RND_MUL_W steps every cycle, and the warmup count increments.
  - After WARMUP_CYC cycles, go to RUN.
- RUN:
  - `rnd_valid`=1, `seed_ready`=1.
  - The LFSR advances N steps only in a cycle where `rnd_en`=1.
- Reseed: a seed handshake in RUN returns to LOAD. That chunk is stored as chunk 0, k becomes 1, and `rnd_valid` falls on the next cycle.
- LFSR: Fibonacci, polynomial x^128+x^29+x^27+x^2+1, shifting toward the MSB with the feedback bit entering at bit 0. One cycle applies N unrolled steps.
- Output mapping: `rnd_ref` = LFSR[RND_REF_W-1:0]; `rnd_mul` = LFSR[N-1:RND_REF_W]. Both are ANDed with `rnd_valid`.
- `rnd_en` while `rnd_valid`=0 is ignored. `seed_valid` while `seed_ready`=0 is ignored; the chunk is not consumed.

## Timing
- Reset values: `seed_ready`=1, `rnd_valid`=0, `rnd_ref`=0, `rnd_mul`=0.
- `rnd_valid`, `seed_ready` and the state are registered. Rnd outputs are combinational from the LFSR register and `rnd_valid`.
- First valid randomness arrives WARMUP_CYC+1 cycles after the 4th seed handshake.
- Each `rnd_en`=1 cycle in RUN makes new bits visible on the following cycle. The consumer must not reuse bits across cycles in which `rnd_en`=0, because the same value is held.
- Simultaneous `rnd_en` and a seed handshake in RUN: the reseed wins, and the LFSR takes the chunk write, not an advance.
- `rst` asserted in any state: next cycle is the reset state. Partial seeds are discarded.
- Throughput: one N-bit word per cycle in RUN.

## Structure
- Package `msk_prng_pkg`:
  - state enum {LOAD, WARMUP, RUN};
  - `LFSR_W`=128, `SEED_W`=32, `N_CHUNK`=4;
  - tap positions;
  - zero-seed replacement constant.
- Sub-module `msk_lfsr128_step`: combinational, parameter `STEPS`, maps state to the state after STEPS shifts. It is reused by warmup and run.
- Top: FSM, chunk counter (2 bit), warmup counter (clog2(WARMUP_CYC+1)), output gating.

## Test plan
- Reset, then seed chunks 32'h0000_0001, 0, 0, 0, then hold `rnd_en`=1 → `rnd_valid` rises exactly 129 cycles after the 4th handshake. `rnd_ref`/`rnd_mul` match a software model of 128·20 + k·20 steps.
- All-zero seed (four chunks of 0) → LFSR = 128'h1 entering WARMUP, and the output after warmup equals the model seeded with 1, never all-zero.
- In RUN, `rnd_en`=0 for 5 cycles → outputs constant. `rnd_en`=1 once → exactly one 20-step advance.
- Reseed mid-RUN with `rnd_en`=1 in the same cycle → `rnd_valid`=0 and outputs 0 the next cycle, `seed_ready`=1, three more chunks required.
- `rst` asserted after 2 chunks → `seed_ready`=1, `rnd_valid`=0, and 4 new chunks required.
- `seed_valid`=1 during WARMUP → no chunk consumed and warmup count unaffected.
